// File: rtl/stack_arb.sv
// -----------------------------------------------------------------------------
// stack_arb
//
// Two-requester round-robin arbiter in front of an external stack controller.
// Each granted command is executed as a short sequence:
//   IDLE    -> pick a winner, latch its operation and push data
//   ISSUE   -> fire exactly one push or pop strobe, or reject the command
//   CAPTURE -> (pops only) register the stack output into the winner's rdata
//   RESP    -> one-cycle ack (plus err when rejected), rotate priority
//
// Occupancy is tracked locally so overflow/underflow can be rejected
// without ever strobing the stack.
//
// Ports
//   clk, reset            : single clock, synchronous active-high reset
//   a_req/a_push/a_wdata  : requester A command (held until a_ack)
//   a_ack/a_err/a_rdata   : requester A completion, reject flag, pop data
//   b_*                   : same set for requester B
//   stk_push_en/pop_en    : one-cycle strobes to the stack controller
//   stk_push_data         : data accompanying stk_push_en
//   stk_pop_data          : stack output, valid the cycle after stk_pop_en
//   stk_full              : full flag from the stack controller
//   count / empty         : current occupancy and its zero flag
// -----------------------------------------------------------------------------
module stack_arb #(
  parameter int DEPTH = 8,
  parameter int DW    = 12
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          a_req,
  input  logic          a_push,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic          a_err,
  output logic [DW-1:0] a_rdata,

  input  logic          b_req,
  input  logic          b_push,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic          b_err,
  output logic [DW-1:0] b_rdata,

  output logic          stk_push_en,
  output logic          stk_pop_en,
  output logic [DW-1:0] stk_push_data,
  input  logic [DW-1:0] stk_pop_data,
  input  logic          stk_full,

  output logic [3:0]    count,
  output logic          empty
);

  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t        state_q,   state_d;
  logic          gnt_b_q,   gnt_b_d;    // 1 = current command belongs to B
  logic          prio_b_q,  prio_b_d;   // 1 = B wins the next contention
  logic          op_push_q, op_push_d;  // latched operation of the grantee
  logic [DW-1:0] data_q,    data_d;     // latched push data of the grantee
  logic          err_q,     err_d;      // current command was rejected
  logic [3:0]    count_q,   count_d;

  logic          pick_b;
  logic          push_ok;
  logic          pop_ok;

  logic [DW-1:0] rdata_q [2];
  logic [1:0]    ack_vec;

  // B only wins when A is silent or when it is B's turn on contention.
  assign pick_b  = b_req && (!a_req || prio_b_q);

  // The local count and the controller's full flag must both allow a push;
  // either one alone is enough to reject.
  assign push_ok = (count_q < DEPTH_C) && !stk_full;
  assign pop_ok  = (count_q != 4'd0);

  // ---------------------------------------------------------------------------
  // Next-state and strobe decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    gnt_b_d     = gnt_b_q;
    prio_b_d    = prio_b_q;
    op_push_d   = op_push_q;
    data_d      = data_q;
    err_d       = err_q;
    count_d     = count_q;
    stk_push_en = 1'b0;
    stk_pop_en  = 1'b0;

    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          gnt_b_d   = pick_b;
          op_push_d = pick_b ? b_push  : a_push;
          data_d    = pick_b ? b_wdata : a_wdata;
          err_d     = 1'b0;
          state_d   = ISSUE;
        end
      end

      ISSUE: begin
        if (op_push_q) begin
          if (push_ok) begin
            stk_push_en = 1'b1;
            count_d     = count_q + 4'd1;
          end else begin
            err_d = 1'b1;
          end
          state_d = RESP;
        end else begin
          if (pop_ok) begin
            stk_pop_en = 1'b1;
            count_d    = count_q - 4'd1;
            state_d    = CAPTURE;
          end else begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end

      CAPTURE: begin
        // rdata capture happens in the per-requester registers below.
        state_d = RESP;
      end

      RESP: begin
        // The requester just served yields priority to the other one.
        prio_b_d = !gnt_b_q;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_b_q   <= 1'b0;
      prio_b_q  <= 1'b0;
      op_push_q <= 1'b0;
      data_q    <= '0;
      err_q     <= 1'b0;
      count_q   <= 4'd0;
    end else begin
      state_q   <= state_d;
      gnt_b_q   <= gnt_b_d;
      prio_b_q  <= prio_b_d;
      op_push_q <= op_push_d;
      data_q    <= data_d;
      err_q     <= err_d;
      count_q   <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-requester read data and acknowledge (index 0 = A, 1 = B)
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    // Only the grantee's rdata is refreshed; the other keeps its last value.
    always_ff @(posedge clk) begin
      if (reset) begin
        rdata_q[gi] <= '0;
      end else if ((state_q == CAPTURE) && (gnt_b_q == 1'(gi))) begin
        rdata_q[gi] <= stk_pop_data;
      end
    end

    assign ack_vec[gi] = (state_q == RESP) && (gnt_b_q == 1'(gi));
  end

  assign a_ack         = ack_vec[0];
  assign a_err         = ack_vec[0] && err_q;
  assign a_rdata       = rdata_q[0];

  assign b_ack         = ack_vec[1];
  assign b_err         = ack_vec[1] && err_q;
  assign b_rdata       = rdata_q[1];

  assign stk_push_data = data_q;
  assign count         = count_q;
  assign empty         = (count_q == 4'd0);

endmodule

// File: tb/tb_stack_arb.sv
// -----------------------------------------------------------------------------
// tb_stack_arb
//
// Bench for stack_arb. A small behavioural stack controller sits on the stack
// side. Every command's expected response (requester, latency, err, strobe
// counts, pop data) is computed from a reference stack and pushed to a
// scoreboard queue before the command is driven; it is popped and compared
// when the ack appears.
// -----------------------------------------------------------------------------
module tb_stack_arb;

  localparam int DEPTH = 8;
  localparam int DW    = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_req, a_push, a_ack, a_err;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_req, b_push, b_ack, b_err;
  logic [DW-1:0] b_wdata, b_rdata;
  logic          stk_push_en, stk_pop_en, stk_full;
  logic [DW-1:0] stk_push_data, stk_pop_data;
  logic [3:0]    count;
  logic          empty;

  always #5 clk = ~clk;

  stack_arb #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .a_req        (a_req),
    .a_push       (a_push),
    .a_wdata      (a_wdata),
    .a_ack        (a_ack),
    .a_err        (a_err),
    .a_rdata      (a_rdata),
    .b_req        (b_req),
    .b_push       (b_push),
    .b_wdata      (b_wdata),
    .b_ack        (b_ack),
    .b_err        (b_err),
    .b_rdata      (b_rdata),
    .stk_push_en  (stk_push_en),
    .stk_pop_en   (stk_pop_en),
    .stk_push_data(stk_push_data),
    .stk_pop_data (stk_pop_data),
    .stk_full     (stk_full),
    .count        (count),
    .empty        (empty)
  );

  // ---------------- behavioural stack controller ----------------
  logic [DW-1:0] mem [DEPTH];
  int            sp;
  logic          force_full;

  assign stk_full = (sp >= DEPTH) || force_full;

  always @(posedge clk) begin
    if (reset) begin
      sp           <= 0;
      stk_pop_data <= '0;
    end else begin
      if (stk_push_en && sp < DEPTH) begin
        mem[sp] <= stk_push_data;
        sp      <= sp + 1;
      end
      if (stk_pop_en && sp > 0) begin
        stk_pop_data <= mem[sp-1];
        sp           <= sp - 1;
      end
    end
  end

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    bit            is_b;
    bit            err;
    bit            chk_rd;
    logic [DW-1:0] rd;
    int            lat;
    int            np;
    int            npp;
  } resp_t;

  resp_t         sb[$];
  logic [DW-1:0] ref_stk[$];
  logic [DW-1:0] push_data_q[$];
  int            exp_cnt;
  int            push_seen, pop_seen, overlap_cnt;
  int            errors = 0;
  int            checks = 0;

  // One clock step; records strobes seen by the stack while out of reset.
  task automatic tick();
    @(negedge clk);
    if (!reset) begin
      if (stk_push_en) begin
        push_seen++;
        push_data_q.push_back(stk_push_data);
      end
      if (stk_pop_en) pop_seen++;
      if (stk_push_en && stk_pop_en) overlap_cnt++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_req = 1'b0; b_req = 1'b0;
    force_full = 1'b0;
    tick();
    tick();
    exp_cnt = 0;
    ref_stk.delete();
    sb.delete();
    push_data_q.delete();
    push_seen = 0; pop_seen = 0; overlap_cnt = 0;
  endtask

  // Reference model: derive the expected response and queue it.
  task automatic expect_cmd(input bit use_b, input bit push, input logic [DW-1:0] wd);
    resp_t e;
    e.is_b = use_b; e.rd = '0; e.chk_rd = 1'b0; e.np = 0; e.npp = 0;
    if (push) begin
      e.err = (exp_cnt >= DEPTH) || force_full;
      e.lat = 2;
      if (!e.err) begin
        e.np = 1;
        ref_stk.push_back(wd);
        exp_cnt++;
      end
    end else begin
      e.err = (exp_cnt == 0);
      e.lat = e.err ? 2 : 3;
      if (!e.err) begin
        e.npp    = 1;
        e.chk_rd = 1'b1;
        e.rd     = ref_stk.pop_back();
        exp_cnt--;
      end
    end
    sb.push_back(e);
  endtask

  // Drive one command and report what the DUT did (lat = -1 on timeout).
  task automatic drive_cmd(input bit use_b, input bit push, input logic [DW-1:0] wd,
                           output int lat, output bit er, output logic [DW-1:0] rd,
                           output int np, output int npp);
    int ps0 = push_seen;
    int pp0 = pop_seen;
    lat = -1; er = 1'b0; rd = '0;
    if (use_b) begin b_req = 1'b1; b_push = push; b_wdata = wd; end
    else       begin a_req = 1'b1; a_push = push; a_wdata = wd; end
    for (int c = 1; c <= 10 && lat < 0; c++) begin
      tick();
      if (use_b ? b_ack : a_ack) begin
        lat = c;
        er  = use_b ? b_err : a_err;
        rd  = use_b ? b_rdata : a_rdata;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    tick();
    np  = push_seen - ps0;
    npp = pop_seen - pp0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if ({a_ack, a_err, b_ack, b_err, stk_push_en, stk_pop_en} !== 6'b0) begin
      errors++;
      $display("FAIL reset_pulses: got %b want 000000", {a_ack, a_err, b_ack, b_err, stk_push_en, stk_pop_en});
    end
    checks++;
    if ({a_rdata, b_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_rdata: got a=%h b=%h want 0", a_rdata, b_rdata);
    end
    checks++;
    if ({count, empty} !== {4'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_count: got count=%0d empty=%b want 0/1", count, empty);
    end
    reset = 1'b0;
    tick();
  endtask

  // A push 0xABC, A pop, then B push to show A's rdata holds.
  task automatic test_push_pop();
    bit            ub [3] = '{1'b0, 1'b0, 1'b1};
    bit            up [3] = '{1'b1, 1'b0, 1'b1};
    logic [DW-1:0] ud [3] = '{12'hABC, 12'h000, 12'h123};
    for (int i = 0; i < 3; i++) begin
      int lat, np, npp; bit er; logic [DW-1:0] rd; resp_t e;
      expect_cmd(ub[i], up[i], ud[i]);
      drive_cmd(ub[i], up[i], ud[i], lat, er, rd, np, npp);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat || er !== e.err || np !== e.np || npp !== e.npp) begin
        errors++;
        $display("FAIL push_pop[%0d] resp: got lat=%0d err=%b push=%0d pop=%0d want lat=%0d err=%b push=%0d pop=%0d", i, lat, er, np, npp, e.lat, e.err, e.np, e.npp);
      end
      if (e.chk_rd) begin
        checks++;
        if (rd !== e.rd) begin
          errors++;
          $display("FAIL push_pop[%0d] rdata: got %h want %h", i, rd, e.rd);
        end
      end
      if (e.np == 1) begin
        checks++;
        if (push_data_q[$] !== ud[i]) begin
          errors++;
          $display("FAIL push_pop[%0d] push_data: got %h want %h", i, push_data_q[$], ud[i]);
        end
      end
      checks++;
      if ({count, empty} !== {4'(exp_cnt), exp_cnt == 0}) begin
        errors++;
        $display("FAIL push_pop[%0d] count: got %0d/%b want %0d/%b", i, count, empty, exp_cnt, exp_cnt == 0);
      end
    end
    checks++;
    if (a_rdata !== 12'hABC) begin
      errors++;
      $display("FAIL a_rdata_hold: got %h want abc", a_rdata);
    end
  endtask

  // B pops the remaining entry, then pops an empty stack.
  task automatic test_underflow();
    for (int i = 0; i < 2; i++) begin
      int lat, np, npp; bit er; logic [DW-1:0] rd; resp_t e;
      expect_cmd(1'b1, 1'b0, '0);
      drive_cmd(1'b1, 1'b0, '0, lat, er, rd, np, npp);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat || er !== e.err || np !== e.np || npp !== e.npp) begin
        errors++;
        $display("FAIL underflow[%0d] resp: got lat=%0d err=%b push=%0d pop=%0d want lat=%0d err=%b push=%0d pop=%0d", i, lat, er, np, npp, e.lat, e.err, e.np, e.npp);
      end
      if (e.chk_rd) begin
        checks++;
        if (rd !== e.rd) begin
          errors++;
          $display("FAIL underflow[%0d] rdata: got %h want %h", i, rd, e.rd);
        end
      end
      checks++;
      if ({count, empty} !== {4'(exp_cnt), exp_cnt == 0}) begin
        errors++;
        $display("FAIL underflow[%0d] count: got %0d/%b want %0d/%b", i, count, empty, exp_cnt, exp_cnt == 0);
      end
    end
  endtask

  // Nine A pushes: the ninth must be rejected.
  task automatic test_overflow();
    for (int i = 0; i < DEPTH + 1; i++) begin
      int lat, np, npp; bit er; logic [DW-1:0] rd; resp_t e;
      logic [DW-1:0] wd = 12'h100 + 12'(i);
      expect_cmd(1'b0, 1'b1, wd);
      drive_cmd(1'b0, 1'b1, wd, lat, er, rd, np, npp);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat || er !== e.err || np !== e.np || npp !== e.npp) begin
        errors++;
        $display("FAIL overflow[%0d] resp: got lat=%0d err=%b push=%0d pop=%0d want lat=%0d err=%b push=%0d pop=%0d", i, lat, er, np, npp, e.lat, e.err, e.np, e.npp);
      end
      checks++;
      if ({count, empty} !== {4'(exp_cnt), exp_cnt == 0}) begin
        errors++;
        $display("FAIL overflow[%0d] count: got %0d/%b want %0d/%b", i, count, empty, exp_cnt, exp_cnt == 0);
      end
    end
  endtask

  // Pop one, then push with stk_full forced (reject), then a normal push.
  task automatic test_full_flag();
    bit up [3] = '{1'b0, 1'b1, 1'b1};
    bit ff [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      int lat, np, npp; bit er; logic [DW-1:0] rd; resp_t e;
      force_full = ff[i];
      expect_cmd(1'b1, up[i], 12'h3C0 + 12'(i));
      drive_cmd(1'b1, up[i], 12'h3C0 + 12'(i), lat, er, rd, np, npp);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat || er !== e.err || np !== e.np || npp !== e.npp) begin
        errors++;
        $display("FAIL full_flag[%0d] resp: got lat=%0d err=%b push=%0d pop=%0d want lat=%0d err=%b push=%0d pop=%0d", i, lat, er, np, npp, e.lat, e.err, e.np, e.npp);
      end
      if (e.chk_rd) begin
        checks++;
        if (rd !== e.rd) begin
          errors++;
          $display("FAIL full_flag[%0d] rdata: got %h want %h", i, rd, e.rd);
        end
      end
      checks++;
      if (count !== 4'(exp_cnt)) begin
        errors++;
        $display("FAIL full_flag[%0d] count: got %0d want %0d", i, count, exp_cnt);
      end
    end
    force_full = 1'b0;
  endtask

  // A and B both requesting from reset: grants alternate A, B, A, B.
  task automatic test_back_to_back();
    int n = 0;
    int both = 0;
    do_reset();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) expect_cmd(k[0], 1'b1, k[0] ? 12'hB22 : 12'hA11);
    a_push = 1'b1; a_wdata = 12'hA11; b_push = 1'b1; b_wdata = 12'hB22;
    a_req = 1'b1; b_req = 1'b1;
    for (int c = 0; c < 60 && n < 4; c++) begin
      tick();
      if (a_ack && b_ack) both++;
      if (a_ack || b_ack) begin
        resp_t e = sb.pop_front();
        checks++;
        if ({b_ack, a_err | b_err} !== {e.is_b, e.err}) begin
          errors++;
          $display("FAIL grant[%0d]: got b_ack=%b err=%b want b_ack=%b err=%b", n, b_ack, a_err | b_err, e.is_b, e.err);
        end
        n++;
        if (n == 4) begin a_req = 1'b0; b_req = 1'b0; end
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    tick();
    checks++;
    if (n !== 4 || both !== 0 || overlap_cnt !== 0) begin
      errors++;
      $display("FAIL back_to_back: got acks=%0d dual_ack=%0d overlap=%0d want 4/0/0", n, both, overlap_cnt);
    end
    checks++;
    if (push_data_q.size() !== 4 || count !== 4'(exp_cnt)) begin
      errors++;
      $display("FAIL back_to_back strobes: got pushes=%0d count=%0d want 4/%0d", push_data_q.size(), count, exp_cnt);
    end
    for (int k = 0; k < push_data_q.size() && k < 4; k++) begin
      checks++;
      if (push_data_q[k] !== ref_stk[k]) begin
        errors++;
        $display("FAIL back_to_back data[%0d]: got %h want %h", k, push_data_q[k], ref_stk[k]);
      end
    end
  endtask

  // Reset arriving while a pop is in CAPTURE aborts it with no ack.
  task automatic test_reset_capture();
    int lat, np, npp, pp0; bit er; logic [DW-1:0] rd; resp_t e;
    int ack_seen = 0;
    do_reset();
    reset = 1'b0;
    expect_cmd(1'b0, 1'b1, 12'h5A5);
    drive_cmd(1'b0, 1'b1, 12'h5A5, lat, er, rd, np, npp);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || er !== e.err || np !== e.np) begin
      errors++;
      $display("FAIL rst_cap setup: got lat=%0d err=%b push=%0d want %0d/%b/%0d", lat, er, np, e.lat, e.err, e.np);
    end
    pp0 = pop_seen;
    a_req = 1'b1; a_push = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (a_ack || b_ack) ack_seen++;
    end
    reset = 1'b1; a_req = 1'b0;
    tick();
    if (a_ack || b_ack) ack_seen++;
    checks++;
    if ({a_ack, a_err, b_ack, b_err, stk_push_en, stk_pop_en} !== 6'b0 || a_rdata !== '0 || {count, empty} !== {4'd0, 1'b1}) begin
      errors++;
      $display("FAIL rst_cap outputs: got pulses=%b a_rdata=%h count=%0d empty=%b want 0/0/0/1", {a_ack, a_err, b_ack, b_err, stk_push_en, stk_pop_en}, a_rdata, count, empty);
    end
    reset = 1'b0;
    exp_cnt = 0; ref_stk.delete();
    for (int c = 0; c < 4; c++) begin
      tick();
      if (a_ack || b_ack) ack_seen++;
    end
    checks++;
    if (ack_seen !== 0 || pop_seen - pp0 !== 1) begin
      errors++;
      $display("FAIL rst_cap abort: got acks=%0d pops=%0d want 0/1", ack_seen, pop_seen - pp0);
    end
    // Arbiter occupancy must also be back at zero: a pop is now an underflow.
    expect_cmd(1'b0, 1'b0, '0);
    drive_cmd(1'b0, 1'b0, '0, lat, er, rd, np, npp);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || er !== e.err || npp !== e.npp) begin
      errors++;
      $display("FAIL rst_cap post_pop: got lat=%0d err=%b pop=%0d want %0d/%b/%0d", lat, er, npp, e.lat, e.err, e.npp);
    end
  endtask

  initial begin
    reset = 1'b1; force_full = 1'b0;
    a_req = 1'b0; a_push = 1'b0; a_wdata = '0;
    b_req = 1'b0; b_push = 1'b0; b_wdata = '0;
    test_reset();
    test_push_pop();
    test_underflow();
    test_overflow();
    test_full_flag();
    test_back_to_back();
    test_reset_capture();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
